// File: rtl/timer_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_controller_pkg
// Description : Shared constants for the timer controller: default counter
//               width and the 2-bit state encoding visible on the state port.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_controller_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_RUN    = 2'b01;
    localparam logic [1:0] c_ST_PAUSED = 2'b10;
    localparam logic [1:0] c_ST_DONE   = 2'b11;

endpackage : timer_controller_pkg
`default_nettype wire

// File: rtl/timer_controller_counter_core.sv
`default_nettype none
// ============================================================================
// Module      : counter_core
// Description : WIDTH-bit up-counter with synchronous clear, enable and
//               load-zero. Clear and load-zero both force zero; they are kept
//               as separate controls so the abort path and the periodic wrap
//               path stay distinguishable at the call site.
// Ports       : clk         - clock
//               rst         - synchronous active-high reset
//               i_clear     - force count to zero (abort / restart)
//               i_enable    - increment by one, modulo 2^WIDTH
//               i_load_zero - force count to zero (periodic wrap)
//               o_count     - current count
// Revision    : 1.0 - initial release
// ============================================================================
module counter_core
    import timer_controller_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_load_zero,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_load_zero) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule : counter_core
`default_nettype wire

// File: rtl/timer_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer_controller
// Description : Programmable one-shot / periodic timer with pause, resume and
//               abort. The FSM and terminal compare live here; the count
//               register lives in counter_core.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset
//               start  - start (IDLE/DONE) or resume (PAUSED)
//               stop   - abort to IDLE from any state (highest priority)
//               pause  - freeze counting while running
//               mode   - 0 one-shot, 1 periodic (latched on start)
//               period - terminal count (latched on start)
//               count  - current counter value
//               tick   - one-cycle pulse at terminal count
//               busy   - RUN or PAUSED
//               done   - DONE
//               err    - registered pulse after a start with period == 0
//               state  - IDLE=00 RUN=01 PAUSED=10 DONE=11
// Revision    : 1.0 - initial release
// ============================================================================
module timer_controller
    import timer_controller_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       state
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_period_q;
    logic             r_mode_q;
    logic             r_err;

    logic [WIDTH-1:0] w_count;
    logic             w_idle_or_done;
    logic             w_accept;
    logic             w_reject;
    logic             w_terminal;
    logic             w_cnt_clear;
    logic             w_cnt_enable;
    logic             w_cnt_load_zero;

    // Start is only considered from IDLE/DONE here; stop outranks it.
    assign w_idle_or_done = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
    assign w_accept       = w_idle_or_done && start && !stop && (period != '0);
    assign w_reject       = w_idle_or_done && start && !stop && (period == '0);
    assign w_terminal     = (r_state == c_ST_RUN) && (w_count == r_period_q);

    // Restart from DONE must discard the held terminal value.
    assign w_cnt_clear     = stop || w_accept;
    assign w_cnt_load_zero = w_terminal && r_mode_q && !stop;
    // A one-shot terminal holds; a pause freezes the current value.
    assign w_cnt_enable    = (r_state == c_ST_RUN) && !w_terminal && !pause && !stop;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_counter_core (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (w_cnt_clear),
        .i_enable    (w_cnt_enable),
        .i_load_zero (w_cnt_load_zero),
        .o_count     (w_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (stop) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_accept) begin
                        w_next_state = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // A one-shot terminal wins over a coincident pause.
                    if (w_terminal && !r_mode_q) begin
                        w_next_state = c_ST_DONE;
                    end else if (pause) begin
                        w_next_state = c_ST_PAUSED;
                    end
                end
                c_ST_PAUSED: begin
                    if (start) begin
                        w_next_state = c_ST_RUN;
                    end
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // Configuration latch and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_q <= '0;
            r_mode_q   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_period_q <= period;
                r_mode_q   <= mode;
            end
        end
    end

    // Outputs: status decoded from the state register only; tick is
    // suppressed by stop or reset in the terminal cycle.
    always_comb begin
        busy  = (r_state == c_ST_RUN) || (r_state == c_ST_PAUSED);
        done  = (r_state == c_ST_DONE);
        state = r_state;
        tick  = w_terminal && !stop && !reset;
        err   = r_err;
        count = w_count;
    end

endmodule : timer_controller
`default_nettype wire

// File: tb/tb_timer_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_controller
// Description : Self-checking bench for timer_controller: directed vectors
//               with hand-computed literals plus a behavioural model compared
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_controller;

    localparam int W = 16;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic         stop   = 1'b0;
    logic         pause  = 1'b0;
    logic         mode   = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] count;
    logic         tick;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   state;

    always #5 clk = ~clk;

    timer_controller #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
        .period (period),
        .count  (count),
        .tick   (tick),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .state  (state)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Phase numbers equal the state port values:
    // 0 idle, 1 running, 2 paused, 3 done.
    // ------------------------------------------------------------------
    int          m_st    = 0;
    int unsigned m_cnt   = 0;
    int unsigned m_per   = 0;
    bit          m_mode  = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : p_model
        int          st;
        int unsigned cnt;
        int unsigned per;
        bit          md;
        bit          e;
        st  = m_st;
        cnt = m_cnt;
        per = m_per;
        md  = m_mode;
        e   = 1'b0;
        if (reset) begin
            st = 0; cnt = 0; per = 0; md = 1'b0;
        end else begin
            e = (st == 0 || st == 3) && start && !stop && (period == 0);
            if (stop) begin
                st = 0; cnt = 0;
            end else if (st == 0 || st == 3) begin
                if (start && period != 0) begin
                    st = 1; cnt = 0; per = period; md = mode;
                end
            end else if (st == 1) begin
                if (cnt == per) begin
                    if (md) begin
                        cnt = 0;
                        if (pause) st = 2;
                    end else begin
                        st = 3;
                    end
                end else if (pause) begin
                    st = 2;
                end else begin
                    cnt = (cnt + 1) % 65536;
                end
            end else if (st == 2) begin
                if (start) st = 1;
            end
        end
        m_st    <= st;
        m_cnt   <= cnt;
        m_per   <= per;
        m_mode  <= md;
        m_err   <= e;
        if (reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_count", count, m_cnt);
            chk("m_tick",  tick,  (m_st == 1 && m_cnt == m_per && !stop && !reset));
            chk("m_busy",  busy,  (m_st == 1 || m_st == 2));
            chk("m_done",  done,  (m_st == 3));
            chk("m_state", state, m_st);
            chk("m_err",   err,   m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_state", state, 2'b00);
        chk("rst_count", count, 0);
        chk("rst_busy",  busy,  0);

        // One-shot, period 3
        period = 16'd3; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            chk("os_count", count, k);
            #1 chk("os_tick", tick, (k == 3));
            cyc();
        end
        chk("os_state", state, 2'b11);
        chk("os_done",  done,  1);
        cyc();
        chk("os_hold", count, 3);

        // Periodic, period 2 (restart from DONE)
        period = 16'd2; mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("per_count", count, k % 3);
            chk("per_busy",  busy,  1);
            #1 chk("per_tick", tick, (k % 3 == 2));
            cyc();
        end
        period = 16'd9; start = 1'b1;   // ignored while running
        cyc();
        start = 1'b0;
        chk("per_ign", count, 2);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("per_stop", state, 2'b00);

        // Zero period rejected
        period = 16'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero_err",   err,   1);
        chk("zero_state", state, 2'b00);
        chk("zero_count", count, 0);
        cyc();
        chk("zero_err_end", err, 0);

        // Pause / resume, period 5
        period = 16'd5; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("pr_c2", count, 2);
        pause = 1'b1;
        repeat (4) cyc();
        chk("pr_hold",  count, 2);
        chk("pr_state", state, 2'b10);
        pause = 1'b0; start = 1'b1; period = 16'd1;
        cyc();
        start = 1'b0;
        chk("pr_resume", state, 2'b01);
        chk("pr_rc",     count, 2);
        cyc(); chk("pr_c3", count, 3);
        cyc(); chk("pr_c4", count, 4);
        cyc(); chk("pr_c5", count, 5);
        #1 chk("pr_tick", tick, 1);
        cyc();
        chk("pr_done", state, 2'b11);

        // Pause coincident with periodic terminal
        period = 16'd1; mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        pause = 1'b1;
        #1 chk("pt_tick", tick, 1);
        cyc();
        pause = 1'b0;
        chk("pt_count", count, 0);
        chk("pt_state", state, 2'b10);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // Stop collides with terminal
        period = 16'd4; mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("sc_count", count, 4);
        stop = 1'b1;
        #1 chk("sc_tick", tick, 0);
        cyc();
        stop = 1'b0;
        chk("sc_state", state, 2'b00);
        chk("sc_zero",  count, 0);

        // Reset mid-run
        period = 16'd10; mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (7) cyc();
        chk("rm_count", count, 7);
        reset = 1'b1;
        #1 chk("rm_tick", tick, 0);
        cyc();
        reset = 1'b0;
        chk("rm_state", state, 2'b00);
        chk("rm_zero",  count, 0);
        chk("rm_busy",  busy,  0);
        chk("rm_done",  done,  0);
        chk("rm_tick2", tick,  0);

        // Maximum period
        period = 16'hFFFF; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (65535) cyc();
        chk("max_count", count, 16'hFFFF);
        #1 chk("max_tick", tick, 1);
        cyc();
        chk("max_state", state, 2'b11);
        chk("max_hold",  count, 16'hFFFF);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("max_stop", state, 2'b00);
        cyc();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_timer_controller
`default_nettype wire
